data_memory_arbiter: RTL
========================

// Module: data_memory_arbiter
// PURPOSE
//  Shares the single-port data_memory between two requesters: port 0 is the CPU
//  load/store path and port 1 is the program/data loader.
//  Round-robin arbitration with a req/ack handshake; one memory access per grant.
//  Drives write_enable/address/data_in of data_memory and returns data_out to the
//  granted requester.
//  data_memory write is synchronous (posedge clk while write_enable=1).
//  data_memory read is combinational (data_out = mem[address]).
// PARAMETERS
//  ADDR_W  8  address width, matches data_memory address
//  DATA_W  8  data width, matches data_memory data_in/data_out
// PORTS
//  clk               in   1       system clock, all state on posedge
//  rst_n             in   1       asynchronous active-low reset
//  req0              in   1       port 0 request; hold until ack0
//  we0               in   1       port 0: 1=write, 0=read; hold with req0
//  addr0             in   ADDR_W  port 0 address; hold with req0
//  wdata0            in   DATA_W  port 0 write data; hold with req0
//  ack0              out  1       port 0 one-cycle completion pulse
//  rdata0            out  DATA_W  port 0 read data, valid while ack0=1
//  req1/we1/addr1/wdata1  in      port 1, same rules as port 0
//  ack1/rdata1       out          port 1, same rules as port 0
//  mem_write_enable  out  1       to data_memory write_enable
//  mem_address       out  ADDR_W  to data_memory address
//  mem_data_in       out  DATA_W  to data_memory data_in
//  mem_data_out      in   DATA_W  from data_memory data_out
// BEHAVIOUR
//  Reset values: state=IDLE, ack0=ack1=0, rdata0=rdata1=0, grant=0, last=1.
//  Reset forces mem_write_enable=0 immediately (asynchronous).
//  FSM states: IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE: stays while req0=req1=0.
//  IDLE, any req: latch grant on next edge.
//   - only one req: that port is granted.
//   - both reqs: the port != last is granted; last <= granted port.
//   - first contention after reset is therefore won by port 0.
//   Go to ACCESS.
//  ACCESS (exactly 1 cycle): mem_address/mem_data_in = granted port's addr/wdata.
//   - mem_write_enable = granted port's we; write commits at the edge ending ACCESS.
//   - on that edge, mem_data_out is captured into the granted rdata register.
//   - rdata is captured for writes too, giving the pre-write/current value.
//   Go to DONE.
//  DONE (1 cycle): granted ack=1, rdata held; go to IDLE.
//  Outside ACCESS: mem_write_enable=0; mem_address/mem_data_in = last granted values.
//  Latency: req sampled in IDLE at cycle N -> ACCESS in N+1 -> ack in N+2.
//   Minimum 3 cycles per transaction.
//  Requester deasserts req in the cycle after ack.
//  If req is still high in the IDLE following DONE, it counts as a new request.
//  rdataX holds its value until that port's next capture.
//  The ungranted port's req is ignored until the next IDLE; no starvation.
//  With both ports requesting continuously, grants alternate 0,1,0,1.
//  req dropped mid-transaction (ACCESS/DONE): the transaction still completes and
//   ack still pulses. Requesters must not do this.
//  Reset asserted mid-ACCESS: no write occurs, no ack is issued; FSM is in IDLE
//   on release.
//  The arbiter inserts no address wrap or width conversion; addresses pass through.
// TESTING
//  1. Reset, then req0 write addr=0x0F data=0xF0.
//     -> ack0 pulse 2 cycles after grant; mem[0x0F]=0xF0; ack1 stays 0.
//  2. req1 read addr=0x0F.
//     -> ack1 with rdata1=0xF0; mem_write_enable never 1 during the transaction.
//  3. req0 and req1 asserted in the same cycle after reset, port0 wr 0xF0<-0x0F,
//     port1 wr 0x0F<-0xF0.
//     -> port 0 acked first, port 1 three cycles later; reads back 0x0F and 0xF0.
//  4. Both ports hold req continuously for 6 transactions.
//     -> grant order 0,1,0,1,0,1; ack0/ack1 never high in the same cycle.
//  5. Overwrite: port0 write 0x0F<-0xAA, then read 0x0F.
//     -> write's rdata0=0xF0 (old value); read's rdata0=0xAA.
//  6. Assert rst_n=0 during ACCESS of a write 0x33<-0x55.
//     -> mem_write_enable drops at once; mem[0x33] unchanged; ack0=0; state IDLE.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data_memory between the CPU
// load/store path (port 0) and the program/data loader (port 1).
module data_memory_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_grant;
  logic              r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              w_any_req;
  logic              w_grant_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // On contention the port that did not win last time gets the grant.
  always_comb begin
    w_any_req   = req0 | req1;
    w_grant_sel = 1'b0;
    if (req0 && req1) w_grant_sel = ~r_last;
    else if (req1)    w_grant_sel = 1'b1;
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = ACCESS;
      ACCESS:  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The granted request is latched, so the memory keeps seeing the last
  // granted address/data outside ACCESS and a dropped req cannot corrupt it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (r_state == IDLE && w_any_req) begin
        r_grant <= w_grant_sel;
        r_last  <= w_grant_sel;
        r_we    <= w_grant_sel ? we1 : we0;
        r_addr  <= w_grant_sel ? addr1 : addr0;
        r_wdata <= w_grant_sel ? wdata1 : wdata0;
      end
      if (r_state == ACCESS) begin
        if (r_grant) r_rdata1 <= mem_data_out;
        else         r_rdata0 <= mem_data_out;
      end
    end
  end

  assign mem_write_enable = (r_state == ACCESS) && r_we;
  assign mem_address      = r_addr;
  assign mem_data_in      = r_wdata;
  assign ack0             = (r_state == DONE) && !r_grant;
  assign ack1             = (r_state == DONE) && r_grant;
  assign rdata0           = r_rdata0;
  assign rdata1           = r_rdata1;

endmodule
